profile_sample_buffer: RTL and testbench

Periodic sampler placed directly downstream of the profiling counter module. An interval timer drives the sampling. On each expiry the block snapshots the low 32 bits of the cycle counter and one software-selected event counter into a FIFO. Software drains the FIFO through SPR reads. This lets software build time-series profiles without polling the counters.

---
 rtl/profile_sample_buffer_pkg.sv | 29 ++
 rtl/profile_sample_buffer_fifo.sv | 55 +++++
 rtl/profile_sample_buffer.sv | 175 +++++++++++++++++
 tb/tb_profile_sample_buffer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/profile_sample_buffer_pkg.sv
// profile_sample_buffer_pkg: SPR map, CTRL/STATUS field positions
// and the FIFO entry layout shared by the sampler files.
package profile_sample_buffer_pkg;

  localparam logic [15:0] SPR_CTRL      = 16'hF820;
  localparam logic [15:0] SPR_INTERVAL  = 16'hF821;
  localparam logic [15:0] SPR_STATUS    = 16'hF822;
  localparam logic [15:0] SPR_SAMPLE_LO = 16'hF823;
  localparam logic [15:0] SPR_SAMPLE_HI = 16'hF824;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_SEL_LSB = 1;
  localparam int CTRL_SEL_MSB = 3;
  localparam int CTRL_IRQ     = 4;

  localparam int ST_LEVEL_MSB = 6;
  localparam int ST_OVF       = 8;
  localparam int ST_EMPTY     = 9;
  localparam int ST_FULL      = 10;
  localparam int ST_DROP_LSB  = 16;
  localparam int ST_DROP_MSB  = 23;
  localparam int ST_CLEAR     = 31;

  typedef struct packed {
    logic [31:0] evt;
    logic [31:0] cyc;
  } sample_t;

endpackage

// File: rtl/profile_sample_buffer_fifo.sv
// profile_sample_fifo: DEPTH x 64-bit first-word fall-through FIFO.
// A push is accepted when full only if a pop retires the head that cycle.
module profile_sample_fifo
  import profile_sample_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    i_push,
  input  sample_t i_data,
  input  logic    i_pop,
  output sample_t o_data,
  output logic    o_full,
  output logic    o_empty,
  output logic [AW:0] o_level
);

  sample_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_doPush;
  logic          w_doPop;

  assign o_full   = (r_level == (AW+1)'(DEPTH));
  assign o_empty  = (r_level == '0);
  assign w_doPop  = i_pop & ~o_empty;
  assign w_doPush = i_push & (~o_full | w_doPop);
  assign o_data   = o_empty ? '0 : r_mem[r_rptr];
  assign o_level  = r_level;

  // storage write; when full the slot being written is the head retiring now
  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wptr] <= i_data;
  end

  // pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wptr <= r_wptr + AW'(1);
      if (w_doPop)  r_rptr <= r_rptr + AW'(1);
      if (w_doPush & ~w_doPop)
        r_level <= r_level + (AW+1)'(1);
      else if (~w_doPush & w_doPop)
        r_level <= r_level - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/profile_sample_buffer.sv
// profile_sample_buffer: interval-timed snapshots of cycle/event counters
// drained via SPRs. Define PROFILE_SAMPLE_IRQ_EN to add sampleIrq.
module profile_sample_buffer
  import profile_sample_buffer_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         stall,
  input  logic         weSpsr,
  input  logic [15:0]  spsrWriteIndex,
  input  logic [31:0]  dataFromCore,
  input  logic         reSpsr,
  input  logic [15:0]  spsrReadIndex,
  input  logic         profileEnabled,
  input  logic [31:0]  cycleCount,
  input  logic [255:0] eventCounts,
  output logic [31:0]  dataToCore
`ifdef PROFILE_SAMPLE_IRQ_EN
  ,
  output logic         sampleIrq
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic          r_en;
  logic [2:0]    r_sel;
  logic [31:0]   r_interval;
  logic [31:0]   r_timer;
  logic          r_activeD;
  logic          r_ovf;
  logic [7:0]    r_drop;

  logic          w_wr;
  logic          w_wrCtrl;
  logic          w_wrInt;
  logic          w_wrStat;
  logic          w_active;
  logic          w_rise;
  logic          w_strobe;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic          w_irqEnBit;
  logic [LW-1:0] w_level;
  logic [31:0]   w_newInterval;
  logic [31:0]   w_ctrl;
  logic [31:0]   w_status;
  sample_t       w_sample;
  sample_t       w_head;

  assign w_wr     = weSpsr & ~stall;
  assign w_wrCtrl = w_wr & (spsrWriteIndex == SPR_CTRL);
  assign w_wrInt  = w_wr & (spsrWriteIndex == SPR_INTERVAL);
  assign w_wrStat = w_wr & (spsrWriteIndex == SPR_STATUS);
  assign w_pop    = reSpsr & ~stall & (spsrReadIndex == SPR_SAMPLE_HI);

  assign w_active = r_en & profileEnabled;
  assign w_rise   = w_active & ~r_activeD;
  assign w_strobe = w_active & ~w_rise & (r_timer == '0);
  assign w_drop   = w_strobe & w_full & ~w_pop;

  assign w_newInterval = (dataFromCore == '0) ? 32'd1 : dataFromCore;
  assign w_sample = {eventCounts[{r_sel, 5'd0} +: 32], cycleCount};

  // CTRL enable and counter select
  always_ff @(posedge clock) begin
    if (reset) begin
      r_en  <= 1'b0;
      r_sel <= '0;
    end else if (w_wrCtrl) begin
      r_en  <= dataFromCore[CTRL_EN];
      r_sel <= dataFromCore[CTRL_SEL_MSB:CTRL_SEL_LSB];
    end
  end

  // INTERVAL register, zero stored as one
  always_ff @(posedge clock) begin
    if (reset)        r_interval <= 32'd1;
    else if (w_wrInt) r_interval <= w_newInterval;
  end

  // previous-cycle active, for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) r_activeD <= 1'b0;
    else       r_activeD <= w_active;
  end

  // interval timer: reload on write/rise/expiry, count while active
  always_ff @(posedge clock) begin
    if (reset)         r_timer <= '0;
    else if (w_wrInt)  r_timer <= w_newInterval - 32'd1;
    else if (w_rise)   r_timer <= r_interval - 32'd1;
    else if (w_strobe) r_timer <= r_interval - 32'd1;
    else if (w_active) r_timer <= r_timer - 32'd1;
  end

  // sticky overflow and saturating drop counter
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_wrStat & dataFromCore[ST_CLEAR]) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
      if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  profile_sample_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_strobe),
    .i_data  (w_sample),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

`ifdef PROFILE_SAMPLE_IRQ_EN
  logic r_irqEn;
  logic r_irq;

  // CTRL interrupt enable
  always_ff @(posedge clock) begin
    if (reset)         r_irqEn <= 1'b0;
    else if (w_wrCtrl) r_irqEn <= dataFromCore[CTRL_IRQ];
  end

  // level interrupt: half full or overflowed
  always_ff @(posedge clock) begin
    if (reset) r_irq <= 1'b0;
    else r_irq <= r_irqEn &
                  ((w_level >= LW'(DEPTH / 2)) | r_ovf);
  end

  assign w_irqEnBit = r_irqEn;
  assign sampleIrq  = r_irq;
`else
  assign w_irqEnBit = 1'b0;
`endif

  // SPR read decode
  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_EN] = r_en;
    w_ctrl[CTRL_SEL_MSB:CTRL_SEL_LSB] = r_sel;
    w_ctrl[CTRL_IRQ] = w_irqEnBit;
    w_status = '0;
    w_status[ST_LEVEL_MSB:0] = 7'(w_level);
    w_status[ST_OVF] = r_ovf;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL] = w_full;
    w_status[ST_DROP_MSB:ST_DROP_LSB] = r_drop;
    dataToCore = '0;
    unique case (spsrReadIndex)
      SPR_CTRL:      dataToCore = w_ctrl;
      SPR_INTERVAL:  dataToCore = r_interval;
      SPR_STATUS:    dataToCore = w_status;
      SPR_SAMPLE_LO: dataToCore = w_head.cyc;
      SPR_SAMPLE_HI: dataToCore = w_head.evt;
      default:       dataToCore = '0;
    endcase
  end

endmodule

// File: tb/tb_profile_sample_buffer.sv
// tb_profile_sample_buffer: register table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_profile_sample_buffer;
  import profile_sample_buffer_pkg::*;

  localparam int DEPTH = 16;
`ifdef PROFILE_SAMPLE_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif
  localparam logic [31:0] CTRL_1F = IRQ_BUILD ? 32'h1F : 32'h0F;

  logic         clock = 1'b0;
  logic         reset;
  logic         stall;
  logic         weSpsr;
  logic [15:0]  spsrWriteIndex;
  logic [31:0]  dataFromCore;
  logic         reSpsr;
  logic [15:0]  spsrReadIndex;
  logic [31:0]  dataToCore;
  logic         profileEnabled;
  logic [31:0]  cycleCount;
  logic [255:0] eventCounts;
`ifdef PROFILE_SAMPLE_IRQ_EN
  logic         sampleIrq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  profile_sample_buffer #(
    .DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .weSpsr         (weSpsr),
    .spsrWriteIndex (spsrWriteIndex),
    .dataFromCore   (dataFromCore),
    .reSpsr         (reSpsr),
    .spsrReadIndex  (spsrReadIndex),
    .profileEnabled (profileEnabled),
    .cycleCount     (cycleCount),
    .eventCounts    (eventCounts),
    .dataToCore     (dataToCore)
`ifdef PROFILE_SAMPLE_IRQ_EN
    ,
    .sampleIrq      (sampleIrq)
`endif
  );

  always #5 clock = ~clock;

  // reference model state
  logic [63:0] m_q[$];
  logic        m_en, m_irqen, m_ovf, m_prev, m_irq;
  logic [2:0]  m_sel;
  logic [31:0] m_int;
  logic [7:0]  m_drop;
  longint      m_t = 0;
  longint      m_t0 = 0;

  function automatic logic [31:0] ev(int n, logic [31:0] cc);
    return 32'(n) * 32'h0100_0000 + cc * 32'(n + 3);
  endfunction

  task automatic set_counts();
    for (int n = 0; n < 8; n++)
      eventCounts[n*32 +: 32] = ev(n, cycleCount);
  endtask

  function automatic logic [31:0] m_read(logic [15:0] idx);
    logic [6:0] lvl;
    lvl = 7'(m_q.size());
    case (idx)
      16'hF820: return {27'b0, m_irqen, m_sel, m_en};
      16'hF821: return m_int;
      16'hF822: return {8'h0, m_drop, 5'h0, m_q.size() == DEPTH,
                        m_q.size() == 0, m_ovf, 1'b0, lvl};
      16'hF823: return (m_q.size() > 0) ? m_q[0][31:0] : 32'h0;
      16'hF824: return (m_q.size() > 0) ? m_q[0][63:32] : 32'h0;
      default:  return 32'h0;
    endcase
  endfunction

  // advance the model across one clock edge using the current inputs
  task automatic model_edge();
    logic act, rise, strobe, wr, pop, nirq, drop;
    logic [63:0] smp;
    if (reset) begin
      m_q.delete();
      m_en = 0; m_sel = 0; m_irqen = 0; m_int = 1;
      m_ovf = 0; m_drop = 0; m_prev = 0; m_irq = 0;
      m_t++;
      return;
    end
    act    = m_en & profileEnabled;
    rise   = act & ~m_prev;
    strobe = act & ~rise & ((m_t - m_t0) % longint'(m_int) == 0);
    wr     = weSpsr & ~stall;
    pop    = reSpsr & ~stall & (spsrReadIndex == 16'hF824);
    smp    = {eventCounts[m_sel*32 +: 32], cycleCount};
    nirq   = m_irqen & ((m_q.size() >= DEPTH / 2) | m_ovf);
    drop   = 0;
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (strobe) begin
      if (m_q.size() < DEPTH) m_q.push_back(smp);
      else drop = 1;
    end
    if (wr && spsrWriteIndex == 16'hF822 && dataFromCore[31]) begin
      m_ovf = 0; m_drop = 0;
    end else if (drop) begin
      m_ovf = 1;
      if (m_drop != 8'hFF) m_drop++;
    end
    if (wr && spsrWriteIndex == 16'hF820) begin
      m_en = dataFromCore[0];
      m_sel = dataFromCore[3:1];
      if (IRQ_BUILD) m_irqen = dataFromCore[4];
    end
    if (wr && spsrWriteIndex == 16'hF821) begin
      m_int = (dataFromCore == 0) ? 32'd1 : dataFromCore;
      m_t0 = m_t;
    end
    if (rise) m_t0 = m_t;
    m_prev = act;
    m_irq = nirq;
    m_t++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clock);
    #1;
    weSpsr = 0; reSpsr = 0; stall = 0;
    cycleCount = cycleCount + 1;
    set_counts();
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic rd(input string nm, input logic [15:0] idx,
                    input logic [31:0] exp);
    spsrReadIndex = idx;
    #1;
    check(nm, dataToCore, exp);
  endtask

  task automatic wr(input logic [15:0] idx, input logic [31:0] d);
    weSpsr = 1; spsrWriteIndex = idx; dataFromCore = d;
    step();
  endtask

  task automatic pop_step();
    reSpsr = 1; spsrReadIndex = SPR_SAMPLE_HI;
    step();
  endtask

  typedef struct {
    logic        st;
    logic [15:0] widx;
    logic [31:0] wdata;
    logic [15:0] ridx;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [11];
  logic [31:0] cc_r, cc_s;

  initial begin
    tv[0]  = '{1'b0, SPR_INTERVAL, 32'd0,  SPR_INTERVAL, 32'd1};
    tv[1]  = '{1'b0, SPR_INTERVAL, 32'd7,  SPR_INTERVAL, 32'd7};
    tv[2]  = '{1'b1, SPR_INTERVAL, 32'd3,  SPR_INTERVAL, 32'd7};
    tv[3]  = '{1'b0, SPR_CTRL, 32'h0E,     SPR_CTRL, 32'h0E};
    tv[4]  = '{1'b0, SPR_CTRL, 32'h1F,     SPR_CTRL, CTRL_1F};
    tv[5]  = '{1'b1, SPR_CTRL, 32'h00,     SPR_CTRL, CTRL_1F};
    tv[6]  = '{1'b0, 16'hF830, 32'hFFFF_FFFF, SPR_CTRL, CTRL_1F};
    tv[7]  = '{1'b0, SPR_CTRL, 32'h00,     SPR_CTRL, 32'h0};
    tv[8]  = '{1'b0, SPR_STATUS, 32'h8000_0000, SPR_STATUS, 32'h200};
    tv[9]  = '{1'b0, SPR_SAMPLE_HI, 32'h1234, SPR_SAMPLE_LO, 32'h0};
    tv[10] = '{1'b0, SPR_INTERVAL, 32'd1,  16'hF81F, 32'h0};

    reset = 1; stall = 0; weSpsr = 0; reSpsr = 0;
    spsrWriteIndex = 0; spsrReadIndex = 0; dataFromCore = 0;
    profileEnabled = 0; cycleCount = 0; set_counts();
    step(); step();
    reset = 0;

    rd("rst_status", SPR_STATUS, 32'h200);
    rd("rst_ctrl", SPR_CTRL, 32'h0);
    rd("rst_interval", SPR_INTERVAL, 32'h1);
    rd("rst_lo", SPR_SAMPLE_LO, 32'h0);
`ifdef PROFILE_SAMPLE_IRQ_EN
    check("rst_irq", {31'b0, sampleIrq}, 32'h0);
`endif

    for (int i = 0; i < 11; i++) begin
      stall = tv[i].st;
      wr(tv[i].widx, tv[i].wdata);
      rd($sformatf("vec%0d", i), tv[i].ridx, tv[i].exp);
    end

    // periodic capture, INTERVAL=4, select 2
    wr(SPR_INTERVAL, 32'd4);
    profileEnabled = 1;
    cycleCount = 98; set_counts();
    wr(SPR_CTRL, 32'h05);
    repeat (13) step();
    profileEnabled = 0;
    rd("a_level", SPR_STATUS, 32'h3);
    for (int k = 0; k < 3; k++) begin
      rd($sformatf("a_lo%0d", k), SPR_SAMPLE_LO, 32'd103 + 32'(4 * k));
      reSpsr = 1;
      rd($sformatf("a_hi%0d", k), SPR_SAMPLE_HI, ev(2, 32'd103 + 32'(4 * k)));
      step();
    end
    rd("a_drained", SPR_STATUS, 32'h200);

    // overflow with 20 strobes at INTERVAL=1
    wr(SPR_INTERVAL, 32'd1);
    profileEnabled = 1;
    cc_r = cycleCount;
    repeat (21) step();
    profileEnabled = 0;
    rd("b_ovf", SPR_STATUS, 32'h0004_0510);
    wr(SPR_STATUS, 32'h8000_0000);
    rd("b_clear", SPR_STATUS, 32'h0000_0410);

    // pop on a strobe cycle while full
    profileEnabled = 1;
    step();
    cc_s = cycleCount;
    reSpsr = 1;
    rd("c_head", SPR_SAMPLE_HI, ev(2, cc_r + 1));
    step();
    profileEnabled = 0;
    rd("c_status", SPR_STATUS, 32'h0000_0410);
    rd("c_newhead", SPR_SAMPLE_LO, cc_r + 2);
    repeat (15) pop_step();
    rd("c_tail_lo", SPR_SAMPLE_LO, cc_s);
    rd("c_tail_hi", SPR_SAMPLE_HI, ev(2, cc_s));
    pop_step();
    rd("c_empty", SPR_STATUS, 32'h200);

    // pop while empty, pop under stall
    reSpsr = 1;
    rd("d_empty_hi", SPR_SAMPLE_HI, 32'h0);
    step();
    rd("d_empty_lvl", SPR_STATUS, 32'h200);
    profileEnabled = 1;
    step(); step();
    profileEnabled = 0;
    rd("d_one", SPR_STATUS, 32'h1);
    stall = 1;
    pop_step();
    rd("d_stall", SPR_STATUS, 32'h1);
    pop_step();
    rd("d_popped", SPR_STATUS, 32'h200);

    // enable drop mid-interval, timer reloads on the next rise
    wr(SPR_INTERVAL, 32'd5);
    profileEnabled = 1;
    repeat (7) step();
    profileEnabled = 0;
    rd("e_first", SPR_STATUS, 32'h1);
    repeat (10) step();
    rd("e_hold", SPR_STATUS, 32'h1);
    profileEnabled = 1;
    cc_r = cycleCount;
    for (int k = 1; k <= 6; k++) begin
      step();
      rd($sformatf("e_lvl%0d", k), SPR_STATUS, (k == 6) ? 32'h2 : 32'h1);
    end
    profileEnabled = 0;
    pop_step();
    rd("e_sample", SPR_SAMPLE_LO, cc_r + 5);

    // reset mid-operation
    wr(SPR_INTERVAL, 32'd1);
    profileEnabled = 1;
    repeat (4) step();
    reset = 1;
    step();
    reset = 0;
    profileEnabled = 0;
    rd("f_status", SPR_STATUS, 32'h200);
    rd("f_ctrl", SPR_CTRL, 32'h0);
    rd("f_interval", SPR_INTERVAL, 32'h1);

`ifdef PROFILE_SAMPLE_IRQ_EN
    // interrupt threshold at half full
    wr(SPR_CTRL, 32'h11);
    profileEnabled = 1;
    repeat (9) step();
    profileEnabled = 0;
    rd("g_lvl8", SPR_STATUS, 32'h8);
    check("g_irq_pre", {31'b0, sampleIrq}, 32'h0);
    step();
    check("g_irq_rise", {31'b0, sampleIrq}, 32'h1);
    pop_step();
    rd("g_lvl7", SPR_STATUS, 32'h7);
    check("g_irq_hold", {31'b0, sampleIrq}, 32'h1);
    step();
    check("g_irq_fall", {31'b0, sampleIrq}, 32'h0);
    reset = 1;
    step();
    reset = 0;
`endif

    // randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      int pop_pct;
      pop_pct = ((c / 400) % 2 == 1) ? 60 : 8;
      if (c % 400 == 0) profileEnabled = 1;
      if ($urandom_range(99) < 3) profileEnabled = ~profileEnabled;
      stall = ($urandom_range(9) < 2);
      if ($urandom_range(99) < 5) begin
        weSpsr = 1;
        case ($urandom_range(3))
          0: begin
            spsrWriteIndex = SPR_CTRL;
            dataFromCore = $urandom;
            dataFromCore[0] = ($urandom_range(9) != 0);
          end
          1: begin
            spsrWriteIndex = SPR_INTERVAL;
            dataFromCore = $urandom_range(6);
          end
          2: begin
            spsrWriteIndex = SPR_STATUS;
            dataFromCore = {$urandom_range(1) == 1, 31'($urandom)};
          end
          default: begin
            spsrWriteIndex = 16'hF81E + 16'($urandom_range(8));
            dataFromCore = $urandom;
          end
        endcase
      end
      reSpsr = ($urandom_range(99) < pop_pct);
      if (reSpsr && $urandom_range(1) == 1)
        spsrReadIndex = SPR_SAMPLE_HI;
      else
        spsrReadIndex = 16'hF81E + 16'($urandom_range(8));
      rd("rnd_read", spsrReadIndex, m_read(spsrReadIndex));
`ifdef PROFILE_SAMPLE_IRQ_EN
      check("rnd_irq", {31'b0, sampleIrq}, {31'b0, m_irq});
`endif
      if ($urandom_range(499) == 0) reset = 1;
      step();
      reset = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
